// File: rtl/dram_cas_control.sv
// CAS-side controller for 4164 DRAMs: row hold, column select, CAS/WE timing, RAS-only refresh and precharge.
// DRAM_INPUT_SYNC_EN selects a two-flop synchronizer per async input instead of a single register stage.
module dram_cas_control #(
  parameter int unsigned ROW_HOLD_CYCLES  = 2,
  parameter int unsigned PRECHARGE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nras,
  input  logic        mux,
  input  logic        nrfshd,
  input  logic        nrd,
  input  logic        nwr,
  input  logic [15:0] a,
  output logic [7:0]  ma,
  output logic        ncas,
  output logic        nwe
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ROW  = 3'd1;
  localparam logic [2:0] ST_COL  = 3'd2;
  localparam logic [2:0] ST_CAS  = 3'd3;
  localparam logic [2:0] ST_RFSH = 3'd4;
  localparam logic [2:0] ST_PRE  = 3'd5;

  localparam logic [3:0] ROW_LOAD = 4'(ROW_HOLD_CYCLES - 1);
  localparam logic [3:0] PRE_LOAD = 4'(PRECHARGE_CYCLES - 1);

  // Bit order {mux, nras, nrfshd, nrd, nwr}; reset leaves every strobe inactive.
  localparam logic [4:0] SYNC_RST = 5'b0_1111;

  logic [4:0] sync_d;
  logic [4:0] sync_q;

  always_comb begin
    sync_d = {mux, nras, nrfshd, nrd, nwr};
  end

`ifdef DRAM_INPUT_SYNC_EN
  logic [4:0] meta_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= SYNC_RST;
      sync_q <= SYNC_RST;
    end else begin
      meta_q <= sync_d;
      sync_q <= meta_q;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= SYNC_RST;
    end else begin
      sync_q <= sync_d;
    end
  end
`endif

  logic mux_s, nras_s, nrfshd_s, nrd_s, nwr_s;

  always_comb begin
    {mux_s, nras_s, nrfshd_s, nrd_s, nwr_s} = sync_q;
  end

  logic [2:0] state_d, state_q;
  logic [3:0] cnt_d, cnt_q;
  logic       ncas_d, ncas_q;
  logic       nwe_d, nwe_q;
  logic       sel_col_d, sel_col_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ncas_d    = ncas_q;
    nwe_d     = nwe_q;
    sel_col_d = sel_col_q;

    case (state_q)
      ST_IDLE: begin
        ncas_d    = 1'b1;
        nwe_d     = 1'b1;
        sel_col_d = 1'b0;
        if (!nras_s) begin
          if (!nrfshd_s) begin
            state_d = ST_RFSH;
          end else begin
            state_d = ST_ROW;
            cnt_d   = ROW_LOAD;
          end
        end
      end

      ST_ROW: begin
        if (nras_s) begin
          state_d   = ST_PRE;
          cnt_d     = PRE_LOAD;
          ncas_d    = 1'b1;
          nwe_d     = 1'b1;
          sel_col_d = 1'b0;
        end else if (cnt_q == 4'd0) begin
          if (mux_s) begin
            state_d   = ST_COL;
            sel_col_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_COL: begin
        if (nras_s) begin
          state_d   = ST_PRE;
          cnt_d     = PRE_LOAD;
          ncas_d    = 1'b1;
          nwe_d     = 1'b1;
          sel_col_d = 1'b0;
        end else if (!nrd_s || !nwr_s) begin
          // WE is latched with CAS, so a write is always an early write.
          state_d = ST_CAS;
          ncas_d  = 1'b0;
          nwe_d   = nwr_s;
        end
      end

      ST_CAS, ST_RFSH: begin
        if (nras_s) begin
          state_d   = ST_PRE;
          cnt_d     = PRE_LOAD;
          ncas_d    = 1'b1;
          nwe_d     = 1'b1;
          sel_col_d = 1'b0;
        end
      end

      ST_PRE: begin
        if (cnt_q == 4'd0) begin
          // A RAS that arrived during precharge is picked up here rather than lost.
          if (!nras_s) begin
            if (!nrfshd_s) begin
              state_d = ST_RFSH;
            end else begin
              state_d = ST_ROW;
              cnt_d   = ROW_LOAD;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        cnt_d     = 4'd0;
        ncas_d    = 1'b1;
        nwe_d     = 1'b1;
        sel_col_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      ncas_q    <= 1'b1;
      nwe_q     <= 1'b1;
      sel_col_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ncas_q    <= ncas_d;
      nwe_q     <= nwe_d;
      sel_col_q <= sel_col_d;
    end
  end

  assign ma   = sel_col_q ? a[15:8] : a[7:0];
  assign ncas = ncas_q;
  assign nwe  = nwe_q;

endmodule

// File: tb/tb_dram_cas_control.sv
// Directed bench for dram_cas_control: per-cycle expected ncas/nwe/ma queued with the stimulus, checked after each edge.
module tb_dram_cas_control;

`ifdef DRAM_INPUT_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        nras, mux, nrfshd, nrd, nwr;
  logic [15:0] a;
  logic [7:0]  ma;
  logic        ncas, nwe;

  int n_pass  = 0;
  int n_total = 0;

  logic       sb_ncas[$];
  logic       sb_nwe[$];
  logic [7:0] sb_ma[$];
  string      sb_tag[$];

  dram_cas_control #(
    .ROW_HOLD_CYCLES (2),
    .PRECHARGE_CYCLES(2)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .nras  (nras),
    .mux   (mux),
    .nrfshd(nrfshd),
    .nrd   (nrd),
    .nwr   (nwr),
    .a     (a),
    .ma    (ma),
    .ncas  (ncas),
    .nwe   (nwe)
  );

  always #5 clk = ~clk;

  task automatic tick();
    logic       e_ncas, e_nwe;
    logic [7:0] e_ma;
    string      tag;
    @(posedge clk);
    #1;
    e_ncas = sb_ncas.pop_front();
    e_nwe  = sb_nwe.pop_front();
    e_ma   = sb_ma.pop_front();
    tag    = sb_tag.pop_front();
    n_total++;
    assert (ncas === e_ncas) n_pass++;
    else $error("FAIL %s ncas: got %b want %b", tag, ncas, e_ncas);
    n_total++;
    assert (nwe === e_nwe) n_pass++;
    else $error("FAIL %s nwe: got %b want %b", tag, nwe, e_nwe);
    n_total++;
    assert (ma === e_ma) n_pass++;
    else $error("FAIL %s ma: got %h want %h", tag, ma, e_ma);
  endtask

  task automatic run(input int n, input logic e_ncas, input logic e_nwe,
                     input logic [7:0] e_ma, input string tag);
    for (int i = 0; i < n; i++) begin
      sb_ncas.push_back(e_ncas);
      sb_nwe.push_back(e_nwe);
      sb_ma.push_back(e_ma);
      sb_tag.push_back(tag);
    end
    for (int i = 0; i < n; i++) tick();
  endtask

  // Full access from IDLE; strobe values select read, write or both-low.
  task automatic access(input logic nrd_v, input logic nwr_v, input logic e_nwe, input string tag);
    a = 16'hA55A; mux = 1'b1; nrfshd = 1'b1; nrd = nrd_v; nwr = nwr_v; nras = 1'b0;
    run(LAT + 2, 1'b1, 1'b1, 8'h5A, {tag, "_row"});
    run(1, 1'b1, 1'b1, 8'hA5, {tag, "_col"});
    run(3, 1'b0, e_nwe, 8'hA5, {tag, "_cas"});
    a = 16'h3CC3;
    run(1, 1'b0, e_nwe, 8'h3C, {tag, "_live_a"});
    nrd = 1'b1; nwr = 1'b1;
    run(LAT + 1, 1'b0, e_nwe, 8'h3C, {tag, "_strobe_ignored"});
    nras = 1'b1; mux = 1'b0;
    run(LAT, 1'b0, e_nwe, 8'h3C, {tag, "_ras_lag"});
    run(4, 1'b1, 1'b1, 8'hC3, {tag, "_pre"});
  endtask

  initial begin
    rst = 1'b1; nras = 1'b1; mux = 1'b0; nrfshd = 1'b1; nrd = 1'b1; nwr = 1'b1;
    a = 16'hA55A;
    run(3, 1'b1, 1'b1, 8'h5A, "reset");
    rst = 1'b0;
    run(2, 1'b1, 1'b1, 8'h5A, "idle");

    access(1'b0, 1'b1, 1'b1, "read");
    access(1'b1, 1'b0, 1'b0, "write");
    access(1'b0, 1'b0, 1'b0, "rdwr");

    // RAS-only refresh
    a = 16'hA55A; mux = 1'b1; nrfshd = 1'b0; nrd = 1'b1; nwr = 1'b1; nras = 1'b0;
    run(8, 1'b1, 1'b1, 8'h5A, "rfsh");
    a = 16'h00FF;
    run(1, 1'b1, 1'b1, 8'hFF, "rfsh_live_a");
    nras = 1'b1; nrfshd = 1'b1; mux = 1'b0;
    run(LAT + 3, 1'b1, 1'b1, 8'hFF, "rfsh_pre");

    // Back-to-back: one-clock RAS-high pulse, new RAS seen one clock into PRE
    a = 16'hA55A; mux = 1'b1; nrd = 1'b0; nras = 1'b0;
    run(LAT + 2, 1'b1, 1'b1, 8'h5A, "b2b_row");
    run(1, 1'b1, 1'b1, 8'hA5, "b2b_col");
    run(2, 1'b0, 1'b1, 8'hA5, "b2b_cas");
    nras = 1'b1;
    run(1, 1'b0, 1'b1, 8'hA5, "b2b_lag");
    nras = 1'b0;
    run(LAT - 1, 1'b0, 1'b1, 8'hA5, "b2b_lag2");
    run(4, 1'b1, 1'b1, 8'h5A, "b2b_pre_row");
    run(1, 1'b1, 1'b1, 8'hA5, "b2b_col2");
    run(2, 1'b0, 1'b1, 8'hA5, "b2b_cas2");
    nras = 1'b1; nrd = 1'b1; mux = 1'b0;
    run(LAT, 1'b0, 1'b1, 8'hA5, "b2b_end_lag");
    run(4, 1'b1, 1'b1, 8'h5A, "b2b_end_pre");

    // Abort in ROW; RAS-high and mux arrive together, RAS wins
    nras = 1'b0; mux = 1'b0; nrd = 1'b0;
    run(LAT + 4, 1'b1, 1'b1, 8'h5A, "abort_row");
    nras = 1'b1; mux = 1'b1;
    run(LAT + 4, 1'b1, 1'b1, 8'h5A, "abort_pre");
    mux = 1'b0; nrd = 1'b1;

    // Reset while in CAS of a write
    mux = 1'b1; nwr = 1'b0; nras = 1'b0;
    run(LAT + 2, 1'b1, 1'b1, 8'h5A, "rstcas_row");
    run(1, 1'b1, 1'b1, 8'hA5, "rstcas_col");
    run(2, 1'b0, 1'b0, 8'hA5, "rstcas_cas");
    rst = 1'b1;
    run(1, 1'b1, 1'b1, 8'h5A, "rst_in_cas");
    nras = 1'b1; nwr = 1'b1; mux = 1'b0;
    run(2, 1'b1, 1'b1, 8'h5A, "rst_hold");
    rst = 1'b0;
    run(LAT + 2, 1'b1, 1'b1, 8'h5A, "rst_idle");

    access(1'b0, 1'b1, 1'b1, "read2");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
